// File: rtl/kyber_seq_ctrl.sv
// Operation sequencer for the Kyber polynomial core: latches the requested mode, runs a
// per-mode cycle counter and derives registered RAM strobes and layer markers from it.
module kyber_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode_in,
  input  logic       abort,
  output logic [1:0] mode,
  output logic [7:0] clk_counter,
  output logic       busy,
  output logic       done,
  output logic       rd_en,
  output logic       wr_en,
  output logic       layer_start
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [1:0] ModeNtt    = 2'd0;
  localparam logic [1:0] ModeIntt   = 2'd1;
  localparam logic [1:0] ModeMult   = 2'd2;
  localparam logic [1:0] ModeAddsub = 2'd3;

  state_e     state_q, state_d;
  logic [7:0] cnt_d;
  logic [1:0] mode_d;
  logic       run_d;

  function automatic logic [7:0] last_of(input logic [1:0] m);
    unique case (m)
      ModeNtt, ModeIntt: last_of = 8'd229;
      ModeMult:          last_of = 8'd139;
      default:           last_of = 8'd67;
    endcase
  endfunction

  function automatic logic [7:0] rd_last_of(input logic [1:0] m);
    unique case (m)
      ModeNtt, ModeIntt: rd_last_of = 8'd223;
      ModeMult:          rd_last_of = 8'd127;
      default:           rd_last_of = 8'd63;
    endcase
  endfunction

  // Write strobes trail reads by the address/datapath pipeline depth of each mode.
  function automatic logic wr_hit(input logic [1:0] m, input logic [7:0] c);
    unique case (m)
      ModeNtt, ModeIntt: wr_hit = (c >= 8'd6);
      ModeMult:          wr_hit = (c >= 8'd12) && (c[1:0] == 2'd3);
      ModeAddsub:        wr_hit = (c >= 8'd4) && c[0];
      default:           wr_hit = 1'b0;
    endcase
  endfunction

  function automatic logic ls_hit(input logic [1:0] m, input logic [7:0] c);
    ls_hit = ((m == ModeNtt) || (m == ModeIntt)) && (c[4:0] == 5'd0) && (c <= 8'd223);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = clk_counter;
    mode_d  = mode;
    unique case (state_q)
      StIdle: begin
        cnt_d = 8'd0;
        if (start && !abort) begin
          state_d = StRun;
          mode_d  = mode_in;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
          cnt_d   = 8'd0;
        end else if (clk_counter == last_of(mode)) begin
          state_d = StDone;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = clk_counter + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    endcase
  end

  assign run_d = (state_d == StRun);

  // Outputs are registered from next-state values so they line up with state_q/clk_counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      clk_counter <= 8'd0;
      mode        <= 2'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_en       <= 1'b0;
      wr_en       <= 1'b0;
      layer_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_counter <= cnt_d;
      mode        <= mode_d;
      busy        <= run_d;
      done        <= (state_d == StDone);
      rd_en       <= run_d && (cnt_d <= rd_last_of(mode_d));
      wr_en       <= run_d && wr_hit(mode_d, cnt_d);
      layer_start <= run_d && ls_hit(mode_d, cnt_d);
    end
  end

endmodule

// File: tb/tb_kyber_seq_ctrl.sv
// Self-checking bench for kyber_seq_ctrl: directed vector table, full-operation sequences
// and randomized traffic against a cycle-level behavioural model.
module tb_kyber_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [1:0] mode_in;
  logic [1:0] mode;
  logic [7:0] clk_counter;
  logic       busy, done, rd_en, wr_en, layer_start;

  int total = 0;
  int bad   = 0;

  // Model: phase 0 idle, 1 run, 2 done; cyc = cycles since start.
  int m_phase = 0;
  int m_cyc   = 0;
  int m_mode  = 0;

  always #5 clk = ~clk;

  kyber_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode_in    (mode_in),
    .abort      (abort),
    .mode       (mode),
    .clk_counter(clk_counter),
    .busy       (busy),
    .done       (done),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .layer_start(layer_start)
  );

  function automatic int m_last(input int md);
    return (md < 2) ? 229 : (md == 2) ? 139 : 67;
  endfunction

  function automatic int m_reads(input int md);
    return (md < 2) ? 224 : (md == 2) ? 128 : 64;
  endfunction

  function automatic bit m_wr(input int md, input int c);
    if (md < 2) return c >= 6;
    if (md == 2) return (c >= 15) && ((c - 15) % 4 == 0);
    return (c >= 5) && ((c - 5) % 2 == 0);
  endfunction

  function automatic bit m_ls(input int md, input int c);
    return (md < 2) && (c % 32 == 0) && (c / 32 < 7);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: apply inputs, advance the model, compare every output against it.
  task automatic cycle(input bit s, input int mi, input bit ab, input bit rs);
    bit run;
    start   = s;
    mode_in = mi[1:0];
    abort   = ab;
    rst     = rs;
    @(posedge clk);
    #1;
    if (rs) begin
      m_phase = 0; m_cyc = 0; m_mode = 0;
    end else if (m_phase == 0) begin
      if (s && !ab) begin
        m_phase = 1; m_cyc = 0; m_mode = mi;
      end
    end else if (ab) begin
      m_phase = 0; m_cyc = 0;
    end else if (m_phase == 1) begin
      if (m_cyc == m_last(m_mode)) begin
        m_phase = 2; m_cyc = 0;
      end else begin
        m_cyc++;
      end
    end else begin
      m_phase = 0;
    end
    run = (m_phase == 1);
    chk("busy", int'(busy), int'(run));
    chk("done", int'(done), int'(m_phase == 2));
    chk("clk_counter", int'(clk_counter), run ? m_cyc : 0);
    chk("mode", int'(mode), m_mode);
    chk("rd_en", int'(rd_en), int'(run && (m_cyc < m_reads(m_mode))));
    chk("wr_en", int'(wr_en), int'(run && m_wr(m_mode, m_cyc)));
    chk("layer_start", int'(layer_start), int'(run && m_ls(m_mode, m_cyc)));
  endtask

  // Full operation with optional mid-run start injection, abort or reset (-1 disables).
  task automatic run_op(input int md, input int inj_at, input int abort_at, input int rst_at,
                        input int e_busy, input int e_rd, input int e_wr, input int e_ls);
    int  n_busy = 0, n_rd = 0, n_wr = 0, n_ls = 0;
    bit  got_done = 0, cancelled = 0;
    cycle(1, md, 0, 0);
    for (int i = 0; i < 400 && !got_done && !cancelled; i++) begin
      n_busy += int'(busy);
      n_rd   += int'(rd_en);
      n_wr   += int'(wr_en);
      n_ls   += int'(layer_start);
      if (done) got_done = 1;
      else if (i == abort_at) begin
        cycle(0, 0, 1, 0);
        cancelled = 1;
      end else if (i == rst_at) begin
        cycle(0, 0, 0, 1);
        cancelled = 1;
      end else if (i == inj_at) cycle(1, md ^ 3, 0, 0);
      else cycle(0, 0, 0, 0);
    end
    if (cancelled) begin
      chk("cancel_busy", int'(busy), 0);
      chk("cancel_done", int'(done), 0);
      chk("cancel_cnt", int'(clk_counter), 0);
    end else begin
      chk("done_seen", int'(got_done), 1);
      chk("busy_cycles", n_busy, e_busy);
      chk("rd_count", n_rd, e_rd);
      chk("wr_count", n_wr, e_wr);
      chk("ls_count", n_ls, e_ls);
      cycle(0, md ^ 1, 0, 0);
      chk("mode_hold", int'(mode), md);
    end
  endtask

  typedef struct {
    bit s; int mi; bit ab; bit rs;
    bit busy; bit done; int cnt; int mode; bit rd; bit wr; bit ls;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0};  // reset beats start/abort
    vecs[1]  = '{1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0};  // abort beats start in idle
    vecs[2]  = '{1, 3, 0, 0, 1, 0, 0, 3, 1, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 1, 0, 1, 3, 1, 0, 0};
    vecs[4]  = '{0, 1, 0, 0, 1, 0, 2, 3, 1, 0, 0};
    vecs[5]  = '{1, 2, 0, 0, 1, 0, 3, 3, 1, 0, 0};  // start ignored in run
    vecs[6]  = '{0, 0, 0, 0, 1, 0, 4, 3, 1, 0, 0};
    vecs[7]  = '{0, 0, 0, 0, 1, 0, 5, 3, 1, 1, 0};
    vecs[8]  = '{0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 0};
    vecs[9]  = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1};
    vecs[10] = '{0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0};
    vecs[11] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};

    start = 0; abort = 0; rst = 1; mode_in = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].s, vecs[i].mi, vecs[i].ab, vecs[i].rs);
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].busy));
      chk($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].done));
      chk($sformatf("vec%0d_cnt", i), int'(clk_counter), vecs[i].cnt);
      chk($sformatf("vec%0d_mode", i), int'(mode), vecs[i].mode);
      chk($sformatf("vec%0d_rd", i), int'(rd_en), int'(vecs[i].rd));
      chk($sformatf("vec%0d_wr", i), int'(wr_en), int'(vecs[i].wr));
      chk($sformatf("vec%0d_ls", i), int'(layer_start), int'(vecs[i].ls));
    end

    run_op(0, -1, -1, -1, 230, 224, 224, 7);   // NTT
    run_op(2, -1, -1, -1, 140, 128, 32, 0);    // MULT
    run_op(3, -1, -1, -1, 68, 64, 32, 0);      // ADDSUB
    run_op(1, 100, -1, -1, 230, 224, 224, 7);  // INTT with ignored start at counter 100
    run_op(0, -1, 50, -1, 0, 0, 0, 0);         // NTT aborted at counter 50
    run_op(0, -1, -1, -1, 230, 224, 224, 7);   // restart immediately
    run_op(2, -1, -1, 20, 0, 0, 0, 0);         // MULT reset at counter 20
    chk("rst_mode", int'(mode), 0);
    cycle(1, 2, 1, 0);
    chk("start_abort_idle", int'(busy), 0);

    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 9) == 0, int'($urandom_range(0, 3)),
            $urandom_range(0, 199) == 0, $urandom_range(0, 599) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
